// File: rtl/reflet_vga_txt_term_if.sv
// reflet_vga_txt_term_if: byte-stream input and renderer cell-write output of the text terminal.
interface reflet_vga_txt_term_if #(
    parameter int CD = 8,
    parameter int HW = 7,
    parameter int VW = 6
);
    logic [7:0] data_in;
    logic data_valid, data_ready;
    logic [CD-1:0] R_fg_in, G_fg_in, B_fg_in, R_bg_in, G_bg_in, B_bg_in;
    logic write_en;
    logic [HW-1:0] h_txt_out, cursor_h;
    logic [VW-1:0] v_txt_out, cursor_v;
    logic [7:0] char_out;
    logic [CD-1:0] R_fg_out, G_fg_out, B_fg_out, R_bg_out, G_bg_out, B_bg_out;
    modport master (
        output data_in, data_valid, R_fg_in, G_fg_in, B_fg_in, R_bg_in, G_bg_in, B_bg_in,
        input data_ready, write_en, h_txt_out, v_txt_out, char_out, cursor_h, cursor_v,
        input R_fg_out, G_fg_out, B_fg_out, R_bg_out, G_bg_out, B_bg_out
    );
    modport slave (
        input data_in, data_valid, R_fg_in, G_fg_in, B_fg_in, R_bg_in, G_bg_in, B_bg_in,
        output data_ready, write_en, h_txt_out, v_txt_out, char_out, cursor_h, cursor_v,
        output R_fg_out, G_fg_out, B_fg_out, R_bg_out, G_bg_out, B_bg_out
    );
endinterface

// File: rtl/reflet_vga_txt_term.sv
// reflet_vga_txt_term: byte-stream terminal front end emitting one renderer cell write per character.
// Define REFLET_VGA_TXT_TERM_CLEAR_EN to make FF (0x0C) clear the whole screen.
module reflet_vga_txt_term #(
    parameter int h_size = 640,
    parameter int v_size = 480,
    parameter int color_depth = 8,
    parameter int bit_reduction = 0
) (
    input logic clk,
    input logic reset,
    reflet_vga_txt_term_if.slave bus
);
    localparam int COLS = h_size / 8 / (2 ** bit_reduction);
    localparam int ROWS = v_size / 8 / (2 ** bit_reduction);
    localparam int HW = $clog2(h_size / 8) - bit_reduction;
    localparam int VW = $clog2(v_size / 8) - bit_reduction;
    localparam int CW = 6 * color_depth;
    localparam logic [HW-1:0] H_LAST = HW'(COLS - 1);
    localparam logic [VW-1:0] V_LAST = VW'(ROWS - 1);
    logic we_q, we_n;
    logic [HW-1:0] h_q, h_n, cur_h, cur_h_n, h_adv, h_back;
    logic [VW-1:0] v_q, v_n, cur_v, cur_v_n, v_adv, v_back;
    logic [7:0] char_q, char_n;
    logic [CW-1:0] col_q, col_n, col_in;
    logic accept, printable, last_col, at_origin;
`ifdef REFLET_VGA_TXT_TERM_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state, state_n;
    assign bus.data_ready = state == IDLE;
`else
    assign bus.data_ready = 1'b1;
`endif
    assign col_in = {bus.R_fg_in, bus.G_fg_in, bus.B_fg_in, bus.R_bg_in, bus.G_bg_in, bus.B_bg_in};
    assign {bus.R_fg_out, bus.G_fg_out, bus.B_fg_out, bus.R_bg_out, bus.G_bg_out, bus.B_bg_out} = col_q;
    assign bus.write_en = we_q;
    assign bus.h_txt_out = h_q;
    assign bus.v_txt_out = v_q;
    assign bus.char_out = char_q;
    assign bus.cursor_h = cur_h;
    assign bus.cursor_v = cur_v;
    always_comb begin
        accept = bus.data_valid && bus.data_ready;
        printable = bus.data_in >= 8'h20 && bus.data_in != 8'h7F;
        last_col = cur_h == H_LAST;
        at_origin = cur_h == '0 && cur_v == '0;
        h_adv = last_col ? '0 : cur_h + 1'b1;
        v_adv = cur_v == V_LAST ? '0 : cur_v + 1'b1;
        h_back = cur_h == '0 ? H_LAST : cur_h - 1'b1;
        v_back = cur_h == '0 ? cur_v - 1'b1 : cur_v;
        we_n = 1'b0;
        h_n = h_q;
        v_n = v_q;
        char_n = char_q;
        col_n = col_q;
        cur_h_n = cur_h;
        cur_v_n = cur_v;
`ifdef REFLET_VGA_TXT_TERM_CLEAR_EN
        state_n = state;
`endif
        if (accept && printable) begin
            we_n = 1'b1;
            h_n = cur_h;
            v_n = cur_v;
            char_n = bus.data_in;
            col_n = col_in;
            cur_h_n = h_adv;
            cur_v_n = last_col ? v_adv : cur_v;
        end else if (accept && bus.data_in == 8'h0A) begin
            cur_h_n = '0;
            cur_v_n = v_adv;
        end else if (accept && bus.data_in == 8'h0D) begin
            cur_h_n = '0;
        end else if (accept && bus.data_in == 8'h08 && !at_origin) begin
            we_n = 1'b1;
            h_n = h_back;
            v_n = v_back;
            char_n = 8'h20;
            col_n = col_in;
            cur_h_n = h_back;
            cur_v_n = v_back;
`ifdef REFLET_VGA_TXT_TERM_CLEAR_EN
        // The first blank lands on the accepting edge; the cursor then sweeps and wraps back to the origin.
        end else if (accept && bus.data_in == 8'h0C) begin
            state_n = CLEAR;
            we_n = 1'b1;
            h_n = '0;
            v_n = '0;
            char_n = 8'h20;
            col_n = col_in;
            cur_h_n = HW'(1);
            cur_v_n = '0;
        end else if (state == CLEAR && at_origin) begin
            state_n = IDLE;
        end else if (state == CLEAR) begin
            we_n = 1'b1;
            h_n = cur_h;
            v_n = cur_v;
            char_n = 8'h20;
            cur_h_n = h_adv;
            cur_v_n = last_col ? v_adv : cur_v;
`endif
        end
    end
`ifdef REFLET_VGA_TXT_TERM_CLEAR_EN
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;
`endif
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            we_q <= 1'b0;
            h_q <= '0;
            v_q <= '0;
            char_q <= '0;
            col_q <= '0;
            cur_h <= '0;
            cur_v <= '0;
        end else begin
            we_q <= we_n;
            h_q <= h_n;
            v_q <= v_n;
            char_q <= char_n;
            col_q <= col_n;
            cur_h <= cur_h_n;
            cur_v <= cur_v_n;
        end
endmodule

// File: tb/tb_reflet_vga_txt_term.sv
// tb_reflet_vga_txt_term: directed checks of cell writes, cursor motion, control codes and screen clear.
module tb_reflet_vga_txt_term;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    reflet_vga_txt_term_if bus();
    reflet_vga_txt_term dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.data_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Present one byte and return just after the edge that accepts it.
    task automatic put(input logic [7:0] d, input logic [7:0] bg);
        @(negedge clk);
        bus.data_in = d;
        bus.data_valid = 1'b1;
        {bus.R_bg_in, bus.G_bg_in, bus.B_bg_in} = {bg, bg + 8'd1, bg + 8'd2};
        {bus.R_fg_in, bus.G_fg_in, bus.B_fg_in} = {~bg, 8'h5A, 8'hA5};
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.data_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.data_valid = 1'b0;
        bus.data_in = 8'h00;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.write_en, bus.h_txt_out, bus.v_txt_out, bus.char_out} !== 22'h0) begin
            n_bad++; $display("FAIL reset_write got %h want 0", {bus.write_en, bus.h_txt_out, bus.v_txt_out, bus.char_out});
        end
        n_cmp++;
        if ({bus.R_fg_out, bus.G_fg_out, bus.B_fg_out, bus.R_bg_out, bus.G_bg_out, bus.B_bg_out} !== 48'h0) begin
            n_bad++; $display("FAIL reset_colour got %h want 0", {bus.R_fg_out, bus.G_fg_out, bus.B_fg_out, bus.R_bg_out, bus.G_bg_out, bus.B_bg_out});
        end
        n_cmp++;
        if ({bus.cursor_h, bus.cursor_v} !== 13'h0) begin
            n_bad++; $display("FAIL reset_cursor got %h want 0", {bus.cursor_h, bus.cursor_v});
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (bus.data_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready got %b want 1", bus.data_ready);
        end
    endtask

    task automatic test_print_ab();
        put(8'h41, 8'h10);
        n_cmp++;
        if ({bus.write_en, bus.h_txt_out, bus.v_txt_out, bus.char_out} !== {1'b1, 7'd0, 6'd0, 8'h41}) begin
            n_bad++; $display("FAIL ab_first got %h want %h", {bus.write_en, bus.h_txt_out, bus.v_txt_out, bus.char_out}, {1'b1, 7'd0, 6'd0, 8'h41});
        end
        n_cmp++;
        if ({bus.R_fg_out, bus.R_bg_out, bus.G_bg_out, bus.B_bg_out} !== 32'hEF10_1112) begin
            n_bad++; $display("FAIL ab_colour got %h want ef101112", {bus.R_fg_out, bus.R_bg_out, bus.G_bg_out, bus.B_bg_out});
        end
        put(8'h42, 8'h20);
        n_cmp++;
        if ({bus.write_en, bus.h_txt_out, bus.v_txt_out, bus.char_out} !== {1'b1, 7'd1, 6'd0, 8'h42}) begin
            n_bad++; $display("FAIL ab_second got %h want %h", {bus.write_en, bus.h_txt_out, bus.v_txt_out, bus.char_out}, {1'b1, 7'd1, 6'd0, 8'h42});
        end
        n_cmp++;
        if ({bus.cursor_h, bus.cursor_v} !== {7'd2, 6'd0}) begin
            n_bad++; $display("FAIL ab_cursor got %h want %h", {bus.cursor_h, bus.cursor_v}, {7'd2, 6'd0});
        end
        idle();
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.write_en !== 1'b0) begin
            n_bad++; $display("FAIL ab_pulse_end got %b want 0", bus.write_en);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        repeat (59) put(8'h0A, 8'h00);
        repeat (79) put(8'h2E, 8'h00);
        n_cmp++;
        if ({bus.cursor_h, bus.cursor_v} !== {7'd79, 6'd59}) begin
            n_bad++; $display("FAIL wrap_pre_cursor got %h want %h", {bus.cursor_h, bus.cursor_v}, {7'd79, 6'd59});
        end
        put(8'h58, 8'h33);
        n_cmp++;
        if ({bus.write_en, bus.h_txt_out, bus.v_txt_out, bus.char_out} !== {1'b1, 7'd79, 6'd59, 8'h58}) begin
            n_bad++; $display("FAIL wrap_write got %h want %h", {bus.write_en, bus.h_txt_out, bus.v_txt_out, bus.char_out}, {1'b1, 7'd79, 6'd59, 8'h58});
        end
        n_cmp++;
        if ({bus.cursor_h, bus.cursor_v} !== 13'h0) begin
            n_bad++; $display("FAIL wrap_cursor got %h want 0", {bus.cursor_h, bus.cursor_v});
        end
        idle();
    endtask

    task automatic test_controls();
        do_reset();
        repeat (3) put(8'h0A, 8'h00);
        repeat (5) put(8'h78, 8'h00);
        put(8'h0D, 8'h00);
        n_cmp++;
        if ({bus.write_en, bus.cursor_h, bus.cursor_v} !== {1'b0, 7'd0, 6'd3}) begin
            n_bad++; $display("FAIL cr got %h want %h", {bus.write_en, bus.cursor_h, bus.cursor_v}, {1'b0, 7'd0, 6'd3});
        end
        put(8'h0A, 8'h00);
        n_cmp++;
        if ({bus.write_en, bus.cursor_h, bus.cursor_v} !== {1'b0, 7'd0, 6'd4}) begin
            n_bad++; $display("FAIL lf got %h want %h", {bus.write_en, bus.cursor_h, bus.cursor_v}, {1'b0, 7'd0, 6'd4});
        end
        put(8'h79, 8'h00);
        put(8'h7F, 8'h00);
        n_cmp++;
        if ({bus.write_en, bus.cursor_h, bus.cursor_v} !== {1'b0, 7'd1, 6'd4}) begin
            n_bad++; $display("FAIL del got %h want %h", {bus.write_en, bus.cursor_h, bus.cursor_v}, {1'b0, 7'd1, 6'd4});
        end
        put(8'h01, 8'h00);
        n_cmp++;
        if ({bus.write_en, bus.cursor_h, bus.cursor_v} !== {1'b0, 7'd1, 6'd4}) begin
            n_bad++; $display("FAIL ctrl01 got %h want %h", {bus.write_en, bus.cursor_h, bus.cursor_v}, {1'b0, 7'd1, 6'd4});
        end
        idle();
    endtask

    task automatic test_backspace();
        do_reset();
        repeat (2) put(8'h0A, 8'h00);
        put(8'h08, 8'h34);
        n_cmp++;
        if ({bus.write_en, bus.h_txt_out, bus.v_txt_out, bus.char_out} !== {1'b1, 7'd79, 6'd1, 8'h20}) begin
            n_bad++; $display("FAIL bs_row_write got %h want %h", {bus.write_en, bus.h_txt_out, bus.v_txt_out, bus.char_out}, {1'b1, 7'd79, 6'd1, 8'h20});
        end
        n_cmp++;
        if ({bus.R_bg_out, bus.G_bg_out, bus.B_bg_out} !== 24'h343536) begin
            n_bad++; $display("FAIL bs_colour got %h want 343536", {bus.R_bg_out, bus.G_bg_out, bus.B_bg_out});
        end
        n_cmp++;
        if ({bus.cursor_h, bus.cursor_v} !== {7'd79, 6'd1}) begin
            n_bad++; $display("FAIL bs_row_cursor got %h want %h", {bus.cursor_h, bus.cursor_v}, {7'd79, 6'd1});
        end
        put(8'h08, 8'h34);
        n_cmp++;
        if ({bus.write_en, bus.h_txt_out, bus.v_txt_out, bus.cursor_h} !== {1'b1, 7'd78, 6'd1, 7'd78}) begin
            n_bad++; $display("FAIL bs_col got %h want %h", {bus.write_en, bus.h_txt_out, bus.v_txt_out, bus.cursor_h}, {1'b1, 7'd78, 6'd1, 7'd78});
        end
        do_reset();
        put(8'h08, 8'h34);
        n_cmp++;
        if ({bus.write_en, bus.cursor_h, bus.cursor_v} !== 14'h0) begin
            n_bad++; $display("FAIL bs_origin got %h want 0", {bus.write_en, bus.cursor_h, bus.cursor_v});
        end
        idle();
    endtask

`ifdef REFLET_VGA_TXT_TERM_CLEAR_EN
    task automatic test_clear();
        int bad = 0;
        logic [21:0] exp;
        do_reset();
        put(8'h41, 8'h00);
        put(8'h0C, 8'h12);
        bus.data_valid = 1'b0;
        for (int i = 0; i < 4800; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            exp = {1'b1, 7'(i % 80), 6'(i / 80), 8'h20};
            if ({bus.write_en, bus.h_txt_out, bus.v_txt_out, bus.char_out} !== exp || bus.R_bg_out !== 8'h12 || bus.data_ready !== 1'b0) begin
                if (bad == 0) $display("first bad clear cell %0d got %h want %h ready %b", i, {bus.write_en, bus.h_txt_out, bus.v_txt_out, bus.char_out}, exp, bus.data_ready);
                bad++;
            end
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++; $display("FAIL clear_cells bad %0d want 0", bad);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.write_en, bus.data_ready, bus.cursor_h, bus.cursor_v} !== {1'b0, 1'b1, 13'h0}) begin
            n_bad++; $display("FAIL clear_end got %h want %h", {bus.write_en, bus.data_ready, bus.cursor_h, bus.cursor_v}, {1'b0, 1'b1, 13'h0});
        end
        put(8'h43, 8'h00);
        n_cmp++;
        if ({bus.write_en, bus.h_txt_out, bus.v_txt_out, bus.char_out} !== {1'b1, 7'd0, 6'd0, 8'h43}) begin
            n_bad++; $display("FAIL clear_after got %h want %h", {bus.write_en, bus.h_txt_out, bus.v_txt_out, bus.char_out}, {1'b1, 7'd0, 6'd0, 8'h43});
        end
        put(8'h0C, 8'h12);
        bus.data_valid = 1'b0;
        repeat (99) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.write_en, bus.cursor_h, bus.cursor_v} !== 14'h0) begin
            n_bad++; $display("FAIL clear_abort got %h want 0", {bus.write_en, bus.cursor_h, bus.cursor_v});
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.data_ready, bus.write_en} !== 2'b10) begin
            n_bad++; $display("FAIL clear_abort_ready got %b want 10", {bus.data_ready, bus.write_en});
        end
    endtask
`else
    task automatic test_clear();
        do_reset();
        put(8'h41, 8'h00);
        put(8'h0C, 8'h12);
        n_cmp++;
        if ({bus.write_en, bus.data_ready, bus.cursor_h, bus.cursor_v} !== {1'b0, 1'b1, 7'd1, 6'd0}) begin
            n_bad++; $display("FAIL ff_ignored got %h want %h", {bus.write_en, bus.data_ready, bus.cursor_h, bus.cursor_v}, {1'b0, 1'b1, 7'd1, 6'd0});
        end
        put(8'h42, 8'h00);
        n_cmp++;
        if ({bus.write_en, bus.h_txt_out, bus.v_txt_out, bus.char_out} !== {1'b1, 7'd1, 6'd0, 8'h42}) begin
            n_bad++; $display("FAIL ff_next got %h want %h", {bus.write_en, bus.h_txt_out, bus.v_txt_out, bus.char_out}, {1'b1, 7'd1, 6'd0, 8'h42});
        end
        idle();
    endtask
`endif

    initial begin
        test_reset();
        test_print_ab();
        test_wrap();
        test_controls();
        test_backspace();
        test_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
